// File: rtl/ddr3_init_pkg.sv
// DDR3 init sequencer shared types and constants.
// DFII register map, command bits and the fixed step table.
package ddr3_init_pkg;

  localparam logic [29:0] DFII_BASE = 30'h2400;

  localparam logic [31:0] MR0_DLLRST = 32'h320;
  localparam logic [31:0] MR0_RUN    = 32'h220;
  localparam logic [31:0] MR1        = 32'h006;
  localparam logic [31:0] MR2        = 32'h200;
  localparam logic [31:0] MR3        = 32'h000;

  localparam logic [2:0] OFS_CTRL  = 3'd0;
  localparam logic [2:0] OFS_CMD   = 3'd1;
  localparam logic [2:0] OFS_ISSUE = 3'd2;
  localparam logic [2:0] OFS_ADDR  = 3'd3;
  localparam logic [2:0] OFS_BADDR = 3'd4;

  localparam logic [31:0] CTRL_SEL     = 32'h01;
  localparam logic [31:0] CTRL_CKE     = 32'h02;
  localparam logic [31:0] CTRL_ODT     = 32'h04;
  localparam logic [31:0] CTRL_RESET_N = 32'h08;

  localparam logic [31:0] CMD_CS  = 32'h01;
  localparam logic [31:0] CMD_WE  = 32'h02;
  localparam logic [31:0] CMD_CAS = 32'h04;
  localparam logic [31:0] CMD_RAS = 32'h08;

  localparam logic [31:0] CMD_MRS =
    CMD_RAS | CMD_CAS | CMD_WE | CMD_CS;
  localparam logic [31:0] CMD_ZQCL =
    CMD_WE | CMD_CS;
  localparam logic [31:0] ISSUE = 32'h01;

  localparam logic [31:0] CTRL_PWR =
    CTRL_RESET_N | CTRL_ODT;
  localparam logic [31:0] CTRL_PWR_CKE =
    CTRL_RESET_N | CTRL_ODT | CTRL_CKE;

  localparam int N_STEPS = 29;

  typedef enum logic [1:0] {
    W_NONE,
    W_CKE,
    W_DLLK,
    W_ZQ
  } wait_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  // wt is the pause taken after this write is acked
  typedef struct packed {
    logic [2:0]  ofs;
    logic [31:0] dat;
    wait_e       wt;
  } step_t;

  localparam step_t STEP_TABLE [N_STEPS] = '{
    '{OFS_ADDR,  32'h0,        W_NONE},
    '{OFS_BADDR, 32'h0,        W_NONE},
    '{OFS_CTRL,  CTRL_PWR,     W_CKE },
    '{OFS_CTRL,  CTRL_PWR_CKE, W_NONE},
    '{OFS_ADDR,  MR2,          W_NONE},
    '{OFS_BADDR, 32'd2,        W_NONE},
    '{OFS_CMD,   CMD_MRS,      W_NONE},
    '{OFS_ISSUE, ISSUE,        W_NONE},
    '{OFS_ADDR,  MR3,          W_NONE},
    '{OFS_BADDR, 32'd3,        W_NONE},
    '{OFS_CMD,   CMD_MRS,      W_NONE},
    '{OFS_ISSUE, ISSUE,        W_NONE},
    '{OFS_ADDR,  MR1,          W_NONE},
    '{OFS_BADDR, 32'd1,        W_NONE},
    '{OFS_CMD,   CMD_MRS,      W_NONE},
    '{OFS_ISSUE, ISSUE,        W_NONE},
    '{OFS_ADDR,  MR0_DLLRST,   W_NONE},
    '{OFS_BADDR, 32'd0,        W_NONE},
    '{OFS_CMD,   CMD_MRS,      W_NONE},
    '{OFS_ISSUE, ISSUE,        W_NONE},
    '{OFS_ADDR,  MR0_RUN,      W_NONE},
    '{OFS_BADDR, 32'd0,        W_NONE},
    '{OFS_CMD,   CMD_MRS,      W_NONE},
    '{OFS_ISSUE, ISSUE,        W_DLLK},
    '{OFS_ADDR,  32'h400,      W_NONE},
    '{OFS_BADDR, 32'h0,        W_NONE},
    '{OFS_CMD,   CMD_ZQCL,     W_NONE},
    '{OFS_ISSUE, ISSUE,        W_ZQ  },
    '{OFS_CTRL,  CTRL_SEL,     W_NONE}
  };

endpackage

// File: rtl/ddr3_init_wb_writer.sv
// Single Wishbone write master with ack timeout.
// Holds adr/dat from request until ack or timeout.
module ddr3_init_wb_writer
  import ddr3_init_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [29:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        ok,
  output logic        tmo,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TLIM =
    TW'(ACK_TIMEOUT - 1);

  logic          cyc;
  logic [29:0]   adr;
  logic [31:0]   dat;
  logic [TW-1:0] cnt;

  assign ok  = cyc & wb_ack;
  assign tmo = cyc & ~wb_ack & (cnt == TLIM);

  assign wb_cyc   = cyc;
  assign wb_stb   = cyc;
  assign wb_we    = cyc;
  assign wb_sel   = {4{cyc}};
  assign wb_adr   = adr;
  assign wb_dat_w = dat;

  // Launch on req, end on ack or after ACK_TIMEOUT silent cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 1'b0;
      adr <= '0;
      dat <= '0;
      cnt <= '0;
    end else if (!cyc) begin
      if (req) begin
        cyc <= 1'b1;
        adr <= req_adr;
        dat <= req_dat;
        cnt <= '0;
      end
    end else if (wb_ack || cnt == TLIM) begin
      cyc <= 1'b0;
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer driving the DFII over Wishbone.
// Walks the step table, inserting tCKE/tDLLK/tZQinit pauses.
module ddr3_init_sequencer
  import ddr3_init_pkg::*;
#(
  parameter int unsigned T_CKE       = 50000,
  parameter int unsigned T_DLLK      = 600,
  parameter int unsigned T_ZQINIT    = 600,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  input  logic        wb_ack
);

  localparam logic [4:0] LAST = 5'(N_STEPS - 1);

  state_e      state;
  state_e      state_n;
  logic [4:0]  step;
  logic [4:0]  sel_idx;
  logic [19:0] wcnt;
  logic [19:0] wait_len;
  logic        req;
  logic        ok;
  logic        tmo;
  logic [29:0] req_adr;
  logic [31:0] req_dat;

  function automatic logic [19:0] wait_of(wait_e w);
    logic [19:0] r;
    r = '0;
    unique case (1'b1)
      (w == W_CKE):  r = 20'(T_CKE);
      (w == W_DLLK): r = 20'(T_DLLK);
      (w == W_ZQ):   r = 20'(T_ZQINIT);
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign req_adr = DFII_BASE
                 + 30'(STEP_TABLE[sel_idx].ofs);
  assign req_dat = STEP_TABLE[sel_idx].dat;

  assign busy  = (state == S_WRITE)
              || (state == S_WAIT);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

  ddr3_init_wb_writer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .ok       (ok),
    .tmo      (tmo),
    .wb_adr   (wb_adr),
    .wb_dat_w (wb_dat_w),
    .wb_sel   (wb_sel),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_ack   (wb_ack)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and write request; WAIT always
  // lasts wait_len+1 cycles giving the idle gap
  always_comb begin
    state_n = state;
    req     = 1'b0;
    sel_idx = step;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          req     = 1'b1;
          sel_idx = '0;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ok)
          state_n = (step == LAST) ? S_DONE
                                   : S_WAIT;
        else if (tmo)
          state_n = S_ERROR;
      end
      S_WAIT: begin
        if (wcnt == wait_len) begin
          req     = 1'b1;
          state_n = S_WRITE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Step index and pause counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step     <= '0;
      wcnt     <= '0;
      wait_len <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            step <= '0;
            wcnt <= '0;
          end
        end
        S_WRITE: begin
          if (ok && step != LAST) begin
            step     <= step + 5'd1;
            wait_len <= wait_of(STEP_TABLE[step].wt);
            wcnt     <= '0;
          end
        end
        S_WAIT: begin
          if (wcnt != wait_len) wcnt <= wcnt + 20'd1;
          else                  wcnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: randomized Wishbone slave
// checked against an expected write list built from the rules.
module tb_ddr3_init_sequencer;

  localparam int T_CKE = 10;
  localparam int T_DLLK = 20;
  localparam int T_ZQ = 20;
  localparam int TO = 16;
  localparam int NW = 29;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;

  int compared;
  int mismatched;

  logic [29:0] exp_adr [NW];
  logic [31:0] exp_dat [NW];
  int          exp_gap [NW];
  int          nexp;

  ddr3_init_sequencer #(
    .T_CKE(T_CKE),
    .T_DLLK(T_DLLK),
    .T_ZQINIT(T_ZQ),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .error(error),
    .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w),
    .wb_sel(wb_sel),
    .wb_cyc(wb_cyc),
    .wb_stb(wb_stb),
    .wb_we(wb_we),
    .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic add(input int ofs, input int dat,
                     input int wt);
    if (nexp < NW) begin
      exp_adr[nexp] = 30'(32'h2400 + ofs);
      exp_dat[nexp] = 32'(dat);
      exp_gap[nexp] = 2 + wt;
    end
    nexp++;
  endtask

  task automatic build_model();
    int mrv [5];
    int bnk [5];
    mrv = '{'h200, 'h000, 'h006, 'h320, 'h220};
    bnk = '{2, 3, 1, 0, 0};
    nexp = 0;
    add(3, 0, 0);
    add(4, 0, 0);
    add(0, 'h0C, T_CKE);
    add(0, 'h0E, 0);
    for (int k = 0; k < 5; k++) begin
      add(3, mrv[k], 0);
      add(4, bnk[k], 0);
      add(1, 'h0F, 0);
      add(2, 'h01, (k == 4) ? T_DLLK : 0);
    end
    add(3, 'h400, 0);
    add(4, 0, 0);
    add(1, 'h03, 0);
    add(2, 'h01, T_ZQ);
    add(0, 'h01, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          64'({busy, done, error, wb_cyc,
               wb_stb, wb_we, wb_sel}),
          64'd0);
    check({tag, "_bus"},
          64'({wb_adr, wb_dat_w}), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    start = 1'b0;
    wb_ack = 1'b0;
    #1;
    check_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_seq(input bit rnd,
                         input int dly_idx,
                         input int dly_len,
                         input int noack_idx,
                         input int stop_idx,
                         input int stop_hold,
                         output int nwr,
                         output int nack_hold,
                         output bit fin_done,
                         output bit fin_err,
                         output bit fin_stop);
    int idx = 0;
    int hold = 0;
    int ack_after = 0;
    int cnum = 0;
    int lack = 0;
    bit in_tx = 0;
    bit acked = 0;
    bit first = 1;
    bit fin = 0;
    nack_hold = 0;
    fin_done = 0;
    fin_err = 0;
    fin_stop = 0;
    start = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      cnum++;
      wb_ack = 1'b0;
      start = 1'b0;
      if (first) begin
        check("start_cyc", 64'(wb_cyc), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check("start_err", 64'(error), 64'd0);
        first = 0;
      end
      if (acked) begin
        check("drop_after_ack", 64'(wb_cyc), 64'd0);
        acked = 0;
        in_tx = 0;
      end else if (wb_cyc) begin
        if (!in_tx) begin
          in_tx = 1;
          hold = 0;
          if (idx > 0 && idx <= NW)
            check("gap", 64'(cnum - lack),
                  64'(exp_gap[idx-1]));
          if (idx == dly_idx) ack_after = dly_len;
          else if (rnd) ack_after = $urandom_range(0, 2);
          else ack_after = 0;
        end
        if (idx < NW) begin
          check("adr", 64'(wb_adr), 64'(exp_adr[idx]));
          check("dat", 64'(wb_dat_w), 64'(exp_dat[idx]));
        end else begin
          check("extra_write", 64'(idx), 64'(NW - 1));
        end
        check("sel_we_stb", 64'({wb_sel, wb_we, wb_stb}),
              64'h3F);
        hold++;
        if (stop_hold > 0 && idx == stop_idx
            && hold == stop_hold) begin
          fin_stop = 1;
          fin = 1;
        end else if (idx != noack_idx
                     && hold == ack_after + 1) begin
          wb_ack = 1'b1;
          lack = cnum;
          idx++;
          acked = 1;
        end
      end else begin
        if (in_tx) begin
          nack_hold = hold;
          in_tx = 0;
        end
        if (rnd) wb_ack = ($urandom_range(0, 3) == 0);
      end
      if (done) begin
        fin_done = 1;
        fin = 1;
      end
      if (error) begin
        fin_err = 1;
        fin = 1;
      end
      if (!done && !error)
        check("busy_run", 64'(busy), 64'd1);
      if (stop_hold == 0 && idx == stop_idx) begin
        fin_stop = 1;
        fin = 1;
      end
      if (rnd && busy && !fin)
        start = 1'($urandom_range(0, 1));
    end
    check("finish_in_budget", 64'(fin), 64'd1);
    nwr = idx;
  endtask

  task automatic expect_done(input string tag,
                             input int nwr);
    check({tag, "_writes"}, 64'(nwr), 64'(NW));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cyc"}, 64'(wb_cyc), 64'd0);
  endtask

  initial begin
    int nwr;
    int nh;
    bit fd;
    bit fe;
    bit fs;
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    wb_ack = 1'b0;
    compared = 0;
    mismatched = 0;
    build_model();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(0, -1, 0, -1, -1, 0, nwr, nh, fd, fe, fs);
    expect_done("A", nwr);
    repeat (3) @(negedge clk);
    check("A_done_hold", 64'(done), 64'd1);

    run_seq(1, 12, 5, -1, -1, 0, nwr, nh, fd, fe, fs);
    expect_done("B", nwr);

    run_seq(1, -1, 0, 4, -1, 0, nwr, nh, fd, fe, fs);
    check("C_hold", 64'(nh), 64'(TO));
    check("C_error", 64'(error), 64'd1);
    check("C_busy", 64'(busy), 64'd0);
    check("C_done", 64'(done), 64'd0);
    check("C_cyc", 64'(wb_cyc), 64'd0);
    check("C_writes", 64'(nwr), 64'd4);

    run_seq(1, -1, 0, -1, -1, 0, nwr, nh, fd, fe, fs);
    expect_done("D", nwr);

    run_seq(0, -1, 0, -1, 24, 0, nwr, nh, fd, fe, fs);
    check("E_stop", 64'(fs), 64'd1);
    start = 1'b0;
    @(negedge clk);
    wb_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("E_in_wait", 64'({busy, wb_cyc}), 64'd2);
    apply_reset("E_rst");

    run_seq(1, -1, 0, -1, -1, 0, nwr, nh, fd, fe, fs);
    expect_done("F", nwr);

    run_seq(0, -1, 0, 10, 10, 3, nwr, nh, fd, fe, fs);
    check("G_stop", 64'(fs), 64'd1);
    check("G_cyc_before", 64'(wb_cyc), 64'd1);
    apply_reset("G_rst");

    run_seq(1, -1, 0, -1, -1, 0, nwr, nh, fd, fe, fs);
    expect_done("H", nwr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
